// File: rtl/glip_uart_rx_pkg.sv
// Shared types and constants for the oversampling UART receiver.
//   state_e        : receiver FSM states
//   SAMPLE_OFFSET  : distance (in clk cycles) of the outer vote samples from mid-bit
package glip_uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } state_e;

  localparam int unsigned SAMPLE_OFFSET = 1;

endpackage : glip_uart_rx_pkg

// File: rtl/glip_uart_rx_sync.sv
// Multi-flop synchronizer for an asynchronous single-bit input.
// Flops reset to 1 so an idle-high line reads idle immediately after reset.
//   clk, rst : clock, asynchronous active-high reset
//   d        : asynchronous input
//   q        : synchronized output (STAGES clk cycles of latency)
module glip_uart_rx_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the raw input through the chain, newest bit at index 0.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule : glip_uart_rx_sync

// File: rtl/glip_uart_rx_oversample.sv
// 8N1 UART receiver with DIVISOR-times oversampling and 2-of-3 majority vote
// around mid-bit.
//   clk, rst : clock, asynchronous active-high reset
//   rx       : raw UART line (idle high, asynchronous)
//   data     : last good byte received, held between enable pulses
//   enable   : one-cycle pulse, data valid
//   error    : one-cycle pulse on framing error
//   brk      : one-cycle pulse on line break
//   busy     : high while a frame is in progress
// Optional feature: define GLIP_UART_RX_BREAK_DETECT_EN to report an all-zero
// frame with a low stop bit on brk instead of error.
module glip_uart_rx_oversample
  import glip_uart_rx_pkg::*;
#(
  parameter int unsigned DIVISOR     = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       enable,
  output logic       error,
  output logic       brk,
  output logic       busy
);

  localparam int unsigned CNT_W = $clog2(DIVISOR);
  localparam int unsigned MID   = DIVISOR / 2;

  localparam logic [CNT_W-1:0] CNT_LO   = CNT_W'(MID - SAMPLE_OFFSET);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(MID);
  localparam logic [CNT_W-1:0] CNT_HI   = CNT_W'(MID + SAMPLE_OFFSET);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVISOR - 1);

  logic rxs;

  state_e           state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [2:0]       idx_q,    idx_d;
  logic [7:0]       shift_q,  shift_d;
  logic             s_lo_q,   s_lo_d;
  logic             s_mid_q,  s_mid_d;
  logic [7:0]       data_q,   data_d;
  logic             enable_q, enable_d;
  logic             error_q,  error_d;
  logic             brk_q,    brk_d;
  logic             busy_q,   busy_d;

  logic vote_c;
  logic at_decide_c;
  logic at_wrap_c;

  glip_uart_rx_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rxs)
  );

  // The third vote sample is the live rxs at the decision count.
  assign vote_c      = (s_lo_q & s_mid_q) | (s_lo_q & rxs) | (s_mid_q & rxs);
  assign at_decide_c = (cnt_q == CNT_HI);
  assign at_wrap_c   = (cnt_q == CNT_LAST);

  // Next-state, counters and registered-output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = at_wrap_c ? '0 : cnt_q + CNT_W'(1);
    idx_d    = idx_q;
    shift_d  = shift_q;
    s_lo_d   = (cnt_q == CNT_LO)  ? rxs : s_lo_q;
    s_mid_d  = (cnt_q == CNT_MID) ? rxs : s_mid_q;
    data_d   = data_q;
    enable_d = 1'b0;
    error_d  = 1'b0;
    brk_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rxs) begin
          state_d = ST_START;
        end
      end

      ST_START: begin
        if (at_decide_c && vote_c) begin
          // Start bit did not hold low: treat as a glitch.
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (at_wrap_c) begin
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        if (at_decide_c) begin
          shift_d = {vote_c, shift_q[7:1]};
        end
        if (at_wrap_c) begin
          if (idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end

      ST_STOP: begin
        if (at_decide_c) begin
          cnt_d = '0;
          if (vote_c) begin
            // Return to IDLE immediately so a back-to-back start edge is caught.
            data_d   = shift_q;
            enable_d = 1'b1;
            state_d  = ST_IDLE;
          end else begin
`ifdef GLIP_UART_RX_BREAK_DETECT_EN
            if (shift_q == 8'h00) begin
              brk_d = 1'b1;
            end else begin
              error_d = 1'b1;
            end
`else
            error_d = 1'b1;
`endif
            state_d = ST_WAIT_IDLE;
          end
        end
      end

      ST_WAIT_IDLE: begin
        // Require a full bit time of continuous idle before re-arming.
        if (!rxs) begin
          cnt_d = '0;
        end else if (at_wrap_c) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      s_lo_q   <= 1'b1;
      s_mid_q  <= 1'b1;
      data_q   <= '0;
      enable_q <= 1'b0;
      error_q  <= 1'b0;
      brk_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      s_lo_q   <= s_lo_d;
      s_mid_q  <= s_mid_d;
      data_q   <= data_d;
      enable_q <= enable_d;
      error_q  <= error_d;
      brk_q    <= brk_d;
      busy_q   <= busy_d;
    end
  end

  assign data   = data_q;
  assign enable = enable_q;
  assign error  = error_q;
  assign brk    = brk_q;
  assign busy   = busy_q;

endmodule : glip_uart_rx_oversample

// File: tb/tb_glip_uart_rx_oversample.sv
// Scoreboard bench for glip_uart_rx_oversample (DIVISOR=16, SYNC_STAGES=2).
// Stimulus pushes the expected pulse kind and data value; a negedge monitor
// pops and compares whenever enable, error or brk is high.
module tb_glip_uart_rx_oversample;

  localparam int unsigned DIV = 16;

  localparam logic [2:0] K_EN  = 3'b001;
  localparam logic [2:0] K_ERR = 3'b010;
  localparam logic [2:0] K_BRK = 3'b100;

  typedef struct {
    logic [2:0] kind;
    logic [7:0] data;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       enable;
  logic       error;
  logic       brk;
  logic       busy;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  glip_uart_rx_oversample #(
    .DIVISOR     (DIV),
    .SYNC_STAGES (2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .rx     (rx),
    .data   (data),
    .enable (enable),
    .error  (error),
    .brk    (brk),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [2:0] kind, input logic [7:0] d);
    exp_t e;
    e.kind = kind;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic v, input int n);
    repeat (n) begin
      @(negedge clk);
      rx = v;
    end
  endtask

  // Full 8N1 frame; glitch_bit >= 0 inserts a one-cycle low pulse mid-bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int glitch_bit);
    drive(1'b0, DIV);
    for (int i = 0; i < 8; i++) begin
      if (i == glitch_bit) begin
        drive(b[i], 8);
        drive(1'b0, 1);
        drive(b[i], 7);
      end else begin
        drive(b[i], DIV);
      end
    end
    drive(stop_v, DIV);
    drive(1'b1, 20);
  endtask

  // Monitor: every output pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && (enable || error || brk)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got en=%0b err=%0b brk=%0b data=0x%0h expected none",
                 enable, error, brk, data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_kind", 32'({brk, error, enable}), 32'(e.kind));
        check("pulse_data", 32'(data), 32'(e.data));
      end
    end
  end

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data",   32'(data),   32'h00);
    check("rst_enable", 32'(enable), 32'h0);
    check("rst_error",  32'(error),  32'h0);
    check("rst_brk",    32'(brk),    32'h0);
    check("rst_busy",   32'(busy),   32'h0);
    rst = 1'b0;
    drive(1'b1, 10);

    // Clean frame.
    push(K_EN, 8'hA5);
    send_frame(8'hA5, 1'b1, -1);

    // Short low glitch while idle: START entered, then rejected.
    drive(1'b0, 2);
    drive(1'b1, 3);
    check("glitch_busy_high", 32'(busy), 32'h1);
    drive(1'b1, 11);
    check("glitch_busy_low", 32'(busy), 32'h0);
    drive(1'b1, 4);
    push(K_EN, 8'h3C);
    send_frame(8'h3C, 1'b1, -1);

    // Framing error: data must keep 0x3C.
    push(K_ERR, 8'h3C);
    send_frame(8'h5A, 1'b0, -1);
    drive(1'b1, 16);
    check("err_data_hold", 32'(data), 32'h3C);
    push(K_EN, 8'h01);
    send_frame(8'h01, 1'b1, -1);

    // Glitch inside the vote window of bit 3 is outvoted.
    push(K_EN, 8'hFF);
    send_frame(8'hFF, 1'b1, 3);

    // Reset in the middle of bit 4 of a frame.
    drive(1'b0, DIV);
    for (int i = 0; i < 4; i++) drive(1'b1, DIV);
    drive(1'b0, 8);
    @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    drive(1'b1, 3);
    check("midrst_data", 32'(data), 32'h00);
    check("midrst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    drive(1'b1, 10);
    push(K_EN, 8'h81);
    send_frame(8'h81, 1'b1, -1);

    // Line break: 12 bit times low.
`ifdef GLIP_UART_RX_BREAK_DETECT_EN
    push(K_BRK, 8'h81);
`else
    push(K_ERR, 8'h81);
`endif
    drive(1'b0, 12 * DIV);
    drive(1'b1, 40);
    check("brk_busy_low", 32'(busy), 32'h0);

    drive(1'b1, 20);
    check("missing_pulses", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_glip_uart_rx_oversample
